// File: rtl/dmem_byte_lane.sv
// -----------------------------------------------------------------------------
// dmem_byte_lane
// Byte-addressed data memory for the single-stage RISC-V core. It supports
// RV32I sub-word loads/stores through per-byte lane enables and load sign/zero
// extension, and flags misaligned accesses. After reset a sequential clear
// engine zeroes one word per cycle while busy is high.
//
// Optional build macro: DMEM_SYNC_READ_EN
//   undefined (default) : rdata is combinational (asynchronous read)
//   defined             : rdata is registered, 1-cycle load latency
//
// Ports:
//   clk      in   1   clock, all state updates on posedge
//   rst      in   1   asynchronous active-high reset
//   addr     in   32  byte address, word index = addr[IDX_W+1:2]
//   wdata    in   32  store data (LSBs used for SB/SH)
//   we       in   1   store request
//   re       in   1   load request
//   funct3   in   3   RV32I width/sign code
//   rdata    out  32  load result
//   misalign out  1   current access is misaligned
//   busy     out  1   clear engine active, accesses ignored
// -----------------------------------------------------------------------------
module dmem_byte_lane #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   clr_idx_r;
    logic               busy_s;
    logic [31:0]        mem_r [DEPTH_WORDS];

    logic [IDX_W-1:0]   idx_s;
    logic [31:0]        rd_word_s;
    logic               half_s;
    logic               word_s;
    logic               misalign_s;
    logic [3:0]         be_s;
    logic [31:0]        wd_s;
    logic [31:0]        load_val_s;
    logic               addr_unused_s;

    // Upper address bits wrap by design and are deliberately dropped.
    assign addr_unused_s = ^addr[31:IDX_W+2];
    assign idx_s         = addr[IDX_W+1:2];
    assign rd_word_s     = mem_r[idx_s];

    // Select and extend the addressed byte/halfword of a word.
    function automatic logic [31:0] load_extract(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h000000, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0000, h};
            3'b010:  load_extract = w;
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_s;
        end
    end

    // Clear index: advances one word per cycle while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_idx_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            clr_idx_r <= clr_idx_r + IDX_W'(1);
        end else begin
            clr_idx_r <= '0;
        end
    end

    // FSM next-state logic: leave CLEAR once the last word is written.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_idx_r == {IDX_W{1'b1}}) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_IDLE:  state_s = ST_IDLE;
            default:  state_s = ST_CLEAR;
        endcase
    end

    // FSM output logic.
    always_comb begin
        busy_s = 1'b1;
        case (state_r)
            ST_CLEAR: busy_s = 1'b1;
            ST_IDLE:  busy_s = 1'b0;
            default:  busy_s = 1'b1;
        endcase
    end

    // Alignment check; LHU counts as a halfword only for loads, stores
    // with an undefined funct3 never flag.
    always_comb begin
        half_s     = (re && (funct3 == 3'b001 || funct3 == 3'b101)) ||
                     (we && (funct3 == 3'b001));
        word_s     = (re || we) && (funct3 == 3'b010);
        misalign_s = !busy_s && (re || we) &&
                     ((half_s && addr[0]) || (word_s && (addr[1:0] != 2'b00)));
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be_s = 4'b0000;
        wd_s = wdata;
        if (!busy_s && we && !misalign_s) begin
            case (funct3)
                3'b000: begin
                    be_s = 4'b0001 << addr[1:0];
                    wd_s = {4{wdata[7:0]}};
                end
                3'b001: begin
                    be_s = addr[1] ? 4'b1100 : 4'b0011;
                    wd_s = {2{wdata[15:0]}};
                end
                3'b010: begin
                    be_s = 4'b1111;
                    wd_s = wdata;
                end
                default: begin
                    be_s = 4'b0000;
                    wd_s = wdata;
                end
            endcase
        end else begin
            be_s = 4'b0000;
            wd_s = wdata;
        end
    end

    // Memory array: clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy_s) begin
            mem_r[clr_idx_r] <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
                end
            end
        end
    end

    // Load result before optional registering.
    always_comb begin
        if (!busy_s && re && !misalign_s) begin
            load_val_s = load_extract(rd_word_s, addr[1:0], funct3);
        end else begin
            load_val_s = 32'h0000_0000;
        end
    end

`ifdef DMEM_SYNC_READ_EN
    logic [31:0] rdata_r;

    // Registered read: capture on valid load, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (re && !busy_s) begin
            rdata_r <= load_val_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;
`else
    assign rdata = load_val_s;
`endif

    assign misalign = misalign_s;
    assign busy     = busy_s;

endmodule

// File: tb/tb_dmem_byte_lane.sv
module tb_dmem_byte_lane;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        misalign;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ncyc;

    dmem_byte_lane #(.DEPTH_WORDS(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .funct3   (funct3),
        .rdata    (rdata),
        .misalign (misalign),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        funct3 = f3; addr = a; wdata = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp, input logic exp_mis);
        funct3 = f3; addr = a; re = 1'b1;
        #1;
        check(tag, rdata, exp);
        check({tag, "_mis"}, 32'(misalign), 32'(exp_mis));
        re = 1'b0;
        #1;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0; funct3 = 3'b010;

        // 1: reset and full clear
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("busy_after_rst", 32'(busy), 32'd1);
        re = 1'b1; addr = 32'h3; funct3 = 3'b010; #1;
        check("rdata_busy", rdata, 32'h0);
        check("mis_busy", 32'(misalign), 32'd0);
        re = 1'b0;
        wait_clear(ncyc);
        check("clear_cycles", 32'(ncyc), 32'(DEPTH));
        check("busy_idle", 32'(busy), 32'd0);
        load("lw_0", 3'b010, 32'h0, 32'h0, 1'b0);
        load("lw_ffc", 3'b010, 32'hFFC, 32'h0, 1'b0);

        // 2: SW then SB
        store(3'b010, 32'h8, 32'h11223344);
        store(3'b000, 32'h9, 32'h000000AA);
        load("lw_8", 3'b010, 32'h8, 32'h1122AA44, 1'b0);
        load("lb_9", 3'b000, 32'h9, 32'hFFFFFFAA, 1'b0);
        load("lbu_9", 3'b100, 32'h9, 32'h000000AA, 1'b0);

        // 3: SH upper half
        store(3'b001, 32'h12, 32'h00008001);
        load("lh_12", 3'b001, 32'h12, 32'hFFFF8001, 1'b0);
        load("lhu_12", 3'b101, 32'h12, 32'h00008001, 1'b0);
        load("lw_10", 3'b010, 32'h10, 32'h80010000, 1'b0);
        load("lh_10", 3'b001, 32'h10, 32'h00000000, 1'b0);
        load("lb_13", 3'b000, 32'h13, 32'hFFFFFF80, 1'b0);
        load("lbu_12", 3'b100, 32'h12, 32'h00000001, 1'b0);

        // 4: misaligned store and load
        funct3 = 3'b010; addr = 32'h5; wdata = 32'hDEADBEEF; we = 1'b1; #1;
        check("sw_5_mis", 32'(misalign), 32'd1);
        @(posedge clk); #1; we = 1'b0;
        load("lw_4", 3'b010, 32'h4, 32'h0, 1'b0);
        load("lh_3", 3'b001, 32'h3, 32'h0, 1'b1);
        load("lhu_1", 3'b101, 32'h1, 32'h0, 1'b1);

        // undefined funct3: no write, no misalign, load gives 0
        funct3 = 3'b011; addr = 32'h9; wdata = 32'hFFFFFFFF; we = 1'b1; #1;
        check("st_011_mis", 32'(misalign), 32'd0);
        @(posedge clk); #1; we = 1'b0;
        load("lw_8_keep", 3'b010, 32'h8, 32'h1122AA44, 1'b0);
        load("ld_011", 3'b011, 32'h8, 32'h0, 1'b0);

        // re=0 gives 0
        addr = 32'h8; funct3 = 3'b010; re = 1'b0; #1;
        check("re0", rdata, 32'h0);

        // read during write: old before edge, new after
        addr = 32'h10; funct3 = 3'b010; wdata = 32'h0BADF00D; re = 1'b1; we = 1'b1; #1;
        check("rdw_old", rdata, 32'h80010000);
        @(posedge clk); #1; we = 1'b0; #1;
        check("rdw_new", rdata, 32'h0BADF00D);
        re = 1'b0;

        // 5: address wrap
        store(3'b010, 32'h0, 32'h5);
        store(3'b010, 32'(4 * DEPTH), 32'h7);
        load("lw_wrap", 3'b010, 32'h0, 32'h7, 1'b0);
        load("lw_wrap_hi", 3'b010, 32'(4 * DEPTH), 32'h7, 1'b0);

        // 6: reset, restart mid-clear, store during busy ignored
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        store(3'b010, 32'h20, 32'hCAFEF00D);
        repeat (49) @(posedge clk);
        #1;
        check("busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("busy_restart", 32'(busy), 32'd1);
        wait_clear(ncyc);
        check("restart_cycles", 32'(ncyc), 32'(DEPTH));
        load("lw_20_busy_we", 3'b010, 32'h20, 32'h0, 1'b0);
        load("lw_8_cleared", 3'b010, 32'h8, 32'h0, 1'b0);
        load("lw_10_cleared", 3'b010, 32'h10, 32'h0, 1'b0);
        load("lw_0_cleared", 3'b010, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_byte_lane.md
Name: dmem_byte_lane

Overview:
Parametrised next-generation data memory for the RISC-V single-stage core. It accepts byte addresses and supports RV32I sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) through per-byte lane enables and load sign/zero extension. Misaligned accesses are detected and flagged. Reset no longer clears the whole array in parallel; a sequential clear engine zeroes one word per cycle and holds busy high until it finishes. The block sits between the ALU/store-data path and the writeback mux.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, minimum 4.
IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, do not override.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
addr  input  32  byte address; word index = addr[IDX_W+1:2]; upper bits ignored
wdata  input  32  store data, taken from the LSBs for SB/SH
we  input  1  store request
re  input  1  load request
funct3  input  3  RV32I width/sign code
rdata  output  32  load result
misalign  output  1  current access is misaligned
busy  output  1  clear engine active; accesses ignored

Behaviour:
- FSM states are CLEAR and IDLE.
- rst asserted: state=CLEAR, clr_idx=0, busy=1. rdata=0 and misalign=0 while busy.
- CLEAR: each posedge with rst low writes 0 to word clr_idx, then increments clr_idx.
- After word DEPTH_WORDS-1 is written, the next state is IDLE and busy=0.
- Clear therefore takes exactly DEPTH_WORDS cycles after rst deasserts.
- rst asserted mid-clear restarts the clear at index 0.
- In CLEAR, we and re are ignored and no user write occurs.
- Address wrap: addr modulo 4*DEPTH_WORDS; no out-of-range error.
- Stores (IDLE, we=1) commit at posedge:
  - 000 SB: lane addr[1:0] <= wdata[7:0].
  - 001 SH: lanes {addr[1],1}/{addr[1],0} <= wdata[15:0]; misaligned if addr[0]=1.
  - 010 SW: all lanes <= wdata; misaligned if addr[1:0]!=0.
  - Any other funct3: no write, misalign=0.
  - Unaddressed lanes keep their value.
- Loads (IDLE, re=1) are combinational (asynchronous read):
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend halfword addr[1].
  - 101 LHU: zero-extend halfword addr[1].
  - 010 LW: full word.
  - Other funct3: 0. Alignment rules are the same as for stores.
- misalign = ~busy & (re|we) & (half&addr[0] | word&(addr[1:0]!=0)). Combinational.
- A misaligned store is suppressed. A misaligned load returns 0.
- re=0: rdata=0.
- re and we both set at the same address: rdata shows pre-write contents until the edge and the new contents after it.

Optional Feature:
DMEM_SYNC_READ_EN
- Defined: rdata is registered. It captures the load result at posedge when re=1 and ~busy, giving 1-cycle latency.
  - rdata holds its value when re=0.
  - rdata resets to 0 asynchronously on rst.
  - Read-during-write to the same word returns the old data.
  - misalign stays combinational.
- Undefined: combinational read exactly as described in Behaviour.

Test Plan:
1. Pulse rst for 2 cycles, then release. Required: busy=1 for exactly DEPTH_WORDS cycles, then 0. LW from addr 0x0 and 0xFFC returns 0x00000000.
2. SW 0x11223344 @0x8, then SB 0xAA @0x9. Required: LW @0x8=0x1122AA44, LB @0x9=0xFFFFFFAA, LBU @0x9=0x000000AA.
3. SH 0x8001 @0x12. Required: LH @0x12=0xFFFF8001, LHU @0x12=0x00008001, LW @0x10=0x80010000.
4. SW 0xDEADBEEF @0x5. Required: misalign=1, no write, LW @0x4 unchanged. LH @0x3 gives misalign=1 and rdata=0.
5. Write 0x5 @0x0, then SW 0x7 @(4*DEPTH_WORDS). Required: LW @0x0 returns 0x7 (wrap).
6. Assert rst at clear cycle 100. Required: busy stays high and total clear time is DEPTH_WORDS cycles from the final rst release. A we pulse during busy has no effect.
